// File: rtl/latch_bank_writer_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
// Holds the phase enum, default timing constants and the one-hot enable helper.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_ADDR_W       = 2;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    // Widest bank the helper supports; callers truncate to their own DEPTH.
    localparam int MAX_DEPTH = 64;

    function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned addr);
        return MAX_DEPTH'(1) << addr;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_bank_writer_if.sv
// Request handshake plus latch-bank drive signals for the write sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface latch_bank_writer_if
    import latch_bank_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_data;
    logic [DEPTH-1:0]  latch_en;
    logic [WIDTH-1:0]  latch_d;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  latch_en,
        input  latch_d,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output latch_en,
        output latch_d,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/latch_bank_writer_phase_timer.sv
// Loadable down-counter timing one write phase; expire_o marks the phase's last cycle.
// A zero-length phase is bypassed by loading the following phase's length instead.
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] len_i,
    input  logic [CW-1:0] alt_len_i,
    output logic          skip_o,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        skip_o = (len_i == '0);
        cnt_d  = cnt_q;
        if (load_i) begin
            cnt_d = skip_o ? alt_len_i : len_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of transparent latches: drives data, then a one-hot
// enable pulse, then holds data, so every latch closes on a stable D input.
module latch_bank_writer
    import latch_bank_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input logic                clk,
    input logic                reset,
    latch_bank_writer_if.slave bus
);

    localparam int MAXLEN = max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam int CW     = $clog2(MAXLEN + 1);

    localparam logic [CW-1:0]     SETUP_LEN = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0]     PULSE_LEN = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0]     HOLD_LEN  = CW'(HOLD_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [WIDTH-1:0]  latch_d_q;
    logic [WIDTH-1:0]  latch_d_d;
    logic [DEPTH-1:0]  latch_en_q;
    logic [DEPTH-1:0]  latch_en_d;
    logic              ready_q;
    logic              ready_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic              err_d;

    logic              tmrLoad;
    logic [CW-1:0]     tmrLen;
    logic [CW-1:0]     tmrAlt;
    logic              tmrSkip;
    logic              tmrExpire;
    logic              addrInRange;

    phase_timer #(
        .CW (CW)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmrLoad),
        .len_i     (tmrLen),
        .alt_len_i (tmrAlt),
        .skip_o    (tmrSkip),
        .expire_o  (tmrExpire)
    );

    // Length of the phase entered next, and of the phase after it in case that one is empty.
    always_comb begin
        tmrLen = SETUP_LEN;
        tmrAlt = PULSE_LEN;
        unique case (state_q)
            IDLE: begin
                tmrLen = SETUP_LEN;
                tmrAlt = PULSE_LEN;
            end
            SETUP: begin
                tmrLen = PULSE_LEN;
                tmrAlt = PULSE_LEN;
            end
            OPEN: begin
                tmrLen = HOLD_LEN;
                tmrAlt = '0;
            end
            HOLD: begin
                tmrLen = SETUP_LEN;
                tmrAlt = PULSE_LEN;
            end
            default: begin
                tmrLen = SETUP_LEN;
                tmrAlt = PULSE_LEN;
            end
        endcase
    end

    assign addrInRange = ({1'b0, bus.req_addr} < DEPTH_LIM);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        latch_d_d = latch_d_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmrLoad   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    if (!addrInRange) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = bus.req_addr;
                        latch_d_d = bus.req_data;
                        tmrLoad   = 1'b1;
                        state_d   = tmrSkip ? OPEN : SETUP;
                    end
                end
            end
            SETUP: begin
                if (tmrExpire) begin
                    tmrLoad = 1'b1;
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (tmrExpire) begin
                    tmrLoad = 1'b1;
                    if (tmrSkip) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tmrExpire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the phase they describe.
        latch_en_d = (state_d == OPEN) ? DEPTH'(onehot(32'(addr_d))) : '0;
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            latch_d_q  <= '0;
            latch_en_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            latch_d_q  <= latch_d_d;
            latch_en_q <= latch_en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.latch_en  = latch_en_q;
    assign bus.latch_d   = latch_d_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
